// File: rtl/sample_stream_source.sv
// rtl/sample_stream_source.sv - buffered valid/ready byte-stream source with transfer counter
//
// Purpose: words loaded through a simple write port are queued in a FIFO and
// presented on a valid/ready output stream with hold-until-accepted rules.
// Completed output transfers are counted in sent_count (wraps).
//
// Optional feature macro: STREAM_SOURCE_PATTERN_EN
//   When defined, adds the pattern_en input. While pattern_en is high the write
//   port is ignored and an internal incrementing DATA_WIDTH-bit counter is
//   pushed every cycle the FIFO has room.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   wr_valid/wr_data  load request and word
//   wr_ready          FIFO not full (count != DEPTH)
//   stream_out_valid  FIFO not empty (count != 0)
//   stream_out_data   word at the FIFO head
//   stream_out_ready  downstream accepts the head word
//   count             current FIFO occupancy
//   sent_count        completed output transfers, modulo 2^CNT_WIDTH
//   pattern_en        pattern generator enable (macro builds only)

module sample_stream_source #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         wr_ready,
`ifdef STREAM_SOURCE_PATTERN_EN
   input  logic                         pattern_en,
`endif
   output logic                         stream_out_valid,
   output logic [DATA_WIDTH-1:0]        stream_out_data,
   input  logic                         stream_out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [CNT_WIDTH-1:0]         sent_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0]        CNT_ONE    = CW'(1);
   localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
   localparam logic [CNT_WIDTH-1:0] SENT_ONE   = CNT_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;

   logic                  push_req;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  push;
   logic                  pop;

   // Handshake outputs depend on registered count only, so neither
   // wr_valid nor stream_out_ready has a combinational path to them.
   assign wr_ready         = (count != FULL_COUNT);
   assign stream_out_valid = (count != '0);
   assign stream_out_data  = mem[rd_ptr];

   assign push = push_req && wr_ready;
   assign pop  = stream_out_valid && stream_out_ready;

`ifdef STREAM_SOURCE_PATTERN_EN
   localparam logic [DATA_WIDTH-1:0] PAT_ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] pat_cnt;

   always_comb begin
      push_req  = wr_valid;
      push_data = wr_data;
      if (pattern_en) begin
         push_req  = 1'b1;
         push_data = pat_cnt;
      end
   end

   // Advances only on an actual pattern push so the sequence has no gaps
   // when the FIFO fills.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_cnt <= '0;
      end else if (pattern_en && push) begin
         pat_cnt <= pat_cnt + PAT_ONE;
      end
   end
`else
   always_comb begin
      push_req  = wr_valid;
      push_data = wr_data;
   end
`endif

   // Storage is not reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         sent_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            sent_count <= sent_count + SENT_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_stream_source.sv
// tb/tb_sample_stream_source.sv - directed self-checking bench for sample_stream_source

module tb_sample_stream_source;

   logic       clk;
   logic       rst;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       stream_out_valid;
   logic [7:0] stream_out_data;
   logic       stream_out_ready;
   logic [3:0] count;
   logic [15:0] sent_count;
`ifdef STREAM_SOURCE_PATTERN_EN
   logic       pattern_en;
`endif

   int n_checks;
   int n_pass;

   sample_stream_source #(
      .DATA_WIDTH(8),
      .DEPTH(8),
      .CNT_WIDTH(16)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .wr_valid         (wr_valid),
      .wr_data          (wr_data),
      .wr_ready         (wr_ready),
`ifdef STREAM_SOURCE_PATTERN_EN
      .pattern_en       (pattern_en),
`endif
      .stream_out_valid (stream_out_valid),
      .stream_out_data  (stream_out_data),
      .stream_out_ready (stream_out_ready),
      .count            (count),
      .sent_count       (sent_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1ns so inputs change and outputs
   // are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_q [$];
   logic [7:0] head_tbl [3];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst              = 1'b1;
      wr_valid         = 1'b0;
      wr_data          = 8'h00;
      stream_out_ready = 1'b0;
`ifdef STREAM_SOURCE_PATTERN_EN
      pattern_en       = 1'b0;
`endif
      step();
      step();

      // Reset state
      check("rst_valid", stream_out_valid, 0);
      check("rst_count", count, 0);
      check("rst_sent", sent_count, 0);
      check("rst_wr_ready", wr_ready, 1);
      rst = 1'b0;
      step();
      check("post_rst_wr_ready", wr_ready, 1);

      // Three words streamed through with ready held high
      head_tbl[0] = 8'h11;
      head_tbl[1] = 8'h22;
      head_tbl[2] = 8'h33;
      stream_out_ready = 1'b1;
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = head_tbl[i];
         step();
         check($sformatf("pass_data_%0d", i), stream_out_data, head_tbl[i]);
         check($sformatf("pass_valid_%0d", i), stream_out_valid, 1);
         check($sformatf("pass_count_%0d", i), count, 1);
      end
      wr_valid = 1'b0;
      step();
      check("pass_count_end", count, 0);
      check("pass_sent_end", sent_count, 3);
      check("pass_valid_end", stream_out_valid, 0);

      // Fill to full with ready low; ninth push is dropped
      stream_out_ready = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = 8'(i);
         step();
      end
      check("full_count", count, 8);
      check("full_wr_ready", wr_ready, 0);
      wr_data = 8'hFF;
      step();
      check("full_drop_count", count, 8);
      wr_valid = 1'b0;
      stream_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_data_%0d", i), stream_out_data, 32'(i));
         check($sformatf("drain_valid_%0d", i), stream_out_valid, 1);
         step();
      end
      check("drain_count", count, 0);
      check("drain_sent", sent_count, 11);
      check("drain_no_ff", stream_out_valid, 0);

      // Head held stable under back-pressure
      stream_out_ready = 1'b0;
      wr_valid = 1'b1;
      wr_data = 8'hA5;
      step();
      wr_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold_valid_%0d", i), stream_out_valid, 1);
         check($sformatf("hold_data_%0d", i), stream_out_data, 8'hA5);
         step();
      end
      check("hold_sent", sent_count, 11);

      // Bring occupancy to 4 then push and pop together for 10 cycles
      exp_q = '{8'hA5, 8'hB0, 8'hB1, 8'hB2};
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'hB0 + 8'(i);
         step();
      end
      wr_valid = 1'b0;
      check("simul_start_count", count, 4);
      stream_out_ready = 1'b1;
      wr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr_data = 8'hC0 + 8'(i);
         exp_q.push_back(wr_data);
         check($sformatf("simul_data_%0d", i), stream_out_data, exp_q.pop_front());
         step();
         check($sformatf("simul_count_%0d", i), count, 4);
      end
      wr_valid = 1'b0;
      stream_out_ready = 1'b0;
      check("simul_sent", sent_count, 21);
      check("simul_head", stream_out_data, 8'hC6);

      // Asynchronous reset mid-burst at occupancy 5
      wr_valid = 1'b1;
      wr_data = 8'hD0;
      step();
      wr_valid = 1'b0;
      check("pre_arst_count", count, 5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", stream_out_valid, 0);
      check("arst_count", count, 0);
      check("arst_sent", sent_count, 0);
      step();
      rst = 1'b0;
      wr_valid = 1'b1;
      wr_data = 8'h5A;
      step();
      wr_valid = 1'b0;
      check("after_arst_data", stream_out_data, 8'h5A);
      check("after_arst_count", count, 1);
      stream_out_ready = 1'b1;
      step();
      check("after_arst_sent", sent_count, 1);
      check("after_arst_empty", count, 0);

`ifdef STREAM_SOURCE_PATTERN_EN
      // Pattern generator: 300 cycles with ready high
      rst = 1'b1;
      step();
      rst = 1'b0;
      pattern_en = 1'b1;
      stream_out_ready = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         check($sformatf("pat_data_%0d", k), stream_out_data, 32'((k - 1) % 256));
      end
      check("pat_sent", sent_count, 299);
      check("pat_count", count, 1);
      pattern_en = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
